// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - per-window on-time decoder for three active-low RGB PWM pins (optional PWM_DUTY_DECODER_CHANGE_DET_EN)
module pwm_duty_decoder #(
    parameter int PWM_INTERVAL = 1800,
    parameter int TOLERANCE    = 8,
    localparam int DUTY_W      = $clog2(PWM_INTERVAL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RGB_R_IN,
    input  logic              RGB_G_IN,
    input  logic              RGB_B_IN,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic              valid,
    output logic              change
);

    localparam int CNT_W = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_INTERVAL - 1);

    if (PWM_INTERVAL < 2 || TOLERANCE < 0) begin : g_param_check
        $error("pwm_duty_decoder: PWM_INTERVAL must be >= 2 and TOLERANCE >= 0");
    end

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Pin vectors are ordered {r, g, b}; the synchronizer idles high (LED off).
    logic [2:0] pin_meta;
    logic [2:0] pin_sync;
    logic       act_r;
    logic       act_g;
    logic       act_b;

    logic [CNT_W-1:0]  win_cnt;
    logic              win_end;
    logic              run_end;
    logic              warm_end;

    logic [DUTY_W-1:0] acc_r;
    logic [DUTY_W-1:0] acc_g;
    logic [DUTY_W-1:0] acc_b;
    logic [DUTY_W-1:0] new_r;
    logic [DUTY_W-1:0] new_g;
    logic [DUTY_W-1:0] new_b;

    assign act_r   = ~pin_sync[2];
    assign act_g   = ~pin_sync[1];
    assign act_b   = ~pin_sync[0];
    assign win_end = (win_cnt == CNT_LAST);

    // Final cycle of the window is still in the accumulator's adder, so fold it in here.
    assign new_r = acc_r + {{(DUTY_W-1){1'b0}}, act_r};
    assign new_g = acc_g + {{(DUTY_W-1){1'b0}}, act_g};
    assign new_b = acc_b + {{(DUTY_W-1){1'b0}}, act_b};

    // Two-flop synchronizer for the asynchronous pin inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_meta <= 3'b111;
            pin_sync <= 3'b111;
        end else begin
            pin_meta <= {RGB_R_IN, RGB_G_IN, RGB_B_IN};
            pin_sync <= pin_meta;
        end
    end

    // Free-running window counter; count 0 is the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (win_end) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and window-end qualifiers; the first window only flushes synchronizer fill.
    always_comb begin
        state_d  = state_q;
        run_end  = 1'b0;
        warm_end = 1'b0;
        case (state_q)
            WARMUP: begin
                if (win_end) begin
                    warm_end = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                run_end = win_end;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    // On-time accumulators, cleared at every window end regardless of state.
    always_ff @(posedge clk) begin
        if (rst || win_end) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else begin
            acc_r <= new_r;
            acc_g <= new_g;
            acc_b <= new_b;
        end
    end

    // Publish duty counts and the valid strobe at each RUN window end.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= run_end;
            if (run_end) begin
                duty_r <= new_r;
                duty_g <= new_g;
                duty_b <= new_b;
            end
        end
    end

`ifdef PWM_DUTY_DECODER_CHANGE_DET_EN
    logic [DUTY_W-1:0] prev_r;
    logic [DUTY_W-1:0] prev_g;
    logic [DUTY_W-1:0] prev_b;
    logic              prev_seen;
    logic              moved_any;

    // Unsigned magnitude of the difference, one bit wider so it never wraps.
    function automatic logic moved(input logic [DUTY_W-1:0] a, input logic [DUTY_W-1:0] b);
        logic [DUTY_W:0] ea;
        logic [DUTY_W:0] eb;
        logic [DUTY_W:0] mag;
        ea  = {1'b0, a};
        eb  = {1'b0, b};
        mag = (ea >= eb) ? (ea - eb) : (eb - ea);
        return (32'(mag) > TOLERANCE);
    endfunction

    assign moved_any = moved(new_r, prev_r) | moved(new_g, prev_g) | moved(new_b, prev_b);

    // Compare each report against the previous one; the first report has no reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r    <= '0;
            prev_g    <= '0;
            prev_b    <= '0;
            prev_seen <= 1'b0;
            change    <= 1'b0;
        end else begin
            change <= run_end & prev_seen & moved_any;
            if (run_end) begin
                prev_r    <= new_r;
                prev_g    <= new_g;
                prev_b    <= new_b;
                prev_seen <= 1'b1;
            end
        end
    end
`else
    assign change = 1'b0;
`endif

    logic unused_warm;
    assign unused_warm = warm_end;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - self-checking bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

    localparam int P   = 10;
    localparam int TOL = 1;
    localparam int BIG = 1800;
`ifdef PWM_DUTY_DECODER_CHANGE_DET_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        r_in = 1'b1;
    logic        g_in = 1'b1;
    logic        b_in = 1'b1;
    logic [3:0]  duty_r;
    logic [3:0]  duty_g;
    logic [3:0]  duty_b;
    logic        valid;
    logic        change;
    logic [10:0] duty2_r;
    logic [10:0] duty2_g;
    logic [10:0] duty2_b;
    logic        valid2;
    logic        change2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [2:0] hist [$];

    always #5 clk = ~clk;

    pwm_duty_decoder #(.PWM_INTERVAL(P), .TOLERANCE(TOL)) dut (
        .clk(clk), .rst(rst),
        .RGB_R_IN(r_in), .RGB_G_IN(g_in), .RGB_B_IN(b_in),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .valid(valid), .change(change)
    );

    pwm_duty_decoder #(.PWM_INTERVAL(BIG), .TOLERANCE(TOL)) dut_big (
        .clk(clk), .rst(rst2),
        .RGB_R_IN(1'b0), .RGB_G_IN(1'b0), .RGB_B_IN(1'b0),
        .duty_r(duty2_r), .duty_g(duty2_g), .duty_b(duty2_b),
        .valid(valid2), .change(change2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // On-cycles of window w; a pin level drives the count two cycles later. ch: 2=r 1=g 0=b.
    function automatic int wsum(input int w, input int ch);
        int s;
        s = 0;
        for (int t = w * P; t < w * P + P; t++) begin
            if (t >= 2 && hist[t-2][ch] == 1'b0) s++;
        end
        return s;
    endfunction

    task automatic check_now();
        int  n;
        int  w;
        int  er, eg, eb;
        bit  ev, ec;
        n  = cyc;
        ev = (n >= 2 * P) && (n % P == 0);
        er = 0; eg = 0; eb = 0; ec = 1'b0;
        if (n >= 2 * P) begin
            w  = n / P - 1;
            er = wsum(w, 2);
            eg = wsum(w, 1);
            eb = wsum(w, 0);
            if (CHG_EN && ev && w >= 2) begin
                for (int c = 0; c < 3; c++) begin
                    int d;
                    d = wsum(w, c) - wsum(w - 1, c);
                    if (d < 0) d = -d;
                    if (d > TOL) ec = 1'b1;
                end
            end
        end
        chk("valid", valid, ev);
        chk("duty_r", duty_r, er);
        chk("duty_g", duty_g, eg);
        chk("duty_b", duty_b, eb);
        chk("change", change, ec);
    endtask

    task automatic tick(input logic [2:0] pins);
        check_now();
        {r_in, g_in, b_in} = pins;
        hist.push_back(pins);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int p;
        int dr, dg, db;
        int k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_change", change, 0);
        chk("rst_duty_r", duty_r, 0);
        chk("rst_duty_g", duty_g, 0);
        chk("rst_duty_b", duty_b, 0);
        rst = 1'b0;
        cyc = 0;
        hist.delete();

        // All on
        for (int i = 0; i < 40; i++) tick(3'b000);
        // R on, G off, B toggling
        for (int i = 0; i < 30; i++) tick({1'b0, 1'b1, (cyc % 2 == 1)});
        // Aligned PWM 3/7/10
        for (int i = 0; i < 40; i++) begin
            p = (cyc + 2) % P;
            tick({(p >= 3), (p >= 7), 1'b0});
        end
        // R duty steps 3 -> 4 -> 7, aligned to window start
        while ((cyc + 2) % P != 0) tick(3'b111);
        for (int i = 0; i < 3 * P; i++) begin p = (cyc + 2) % P; tick({(p >= 3), 2'b11}); end
        for (int i = 0; i < 3 * P; i++) begin p = (cyc + 2) % P; tick({(p >= 4), 2'b11}); end
        for (int i = 0; i < 3 * P; i++) begin p = (cyc + 2) % P; tick({(p >= 7), 2'b11}); end
        // Random per-cycle levels
        for (int i = 0; i < 40; i++) tick(3'($urandom));
        // Random per-window duties
        for (int w = 0; w < 5; w++) begin
            dr = $urandom_range(0, P);
            dg = $urandom_range(0, P);
            db = $urandom_range(0, P);
            for (int i = 0; i < P; i++) begin
                p = (cyc + 2) % P;
                tick({(p >= dr), (p >= dg), (p >= db)});
            end
        end

        // Mid-window reset at window count 6
        while (cyc % P != 6) tick(3'($urandom));
        check_now();
        rst = 1'b1;
        {r_in, g_in, b_in} = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        hist.delete();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_duty_r", duty_r, 0);
        chk("mid_rst_duty_b", duty_b, 0);
        for (int i = 0; i < 45; i++) tick(3'($urandom));

        // Full-size window, constantly on
        rst2 = 1'b0;
        k = 0;
        while (!valid2 && k < 4000) begin @(posedge clk); #1; k++; end
        chk("big_first_valid_cycle", k, 2 * BIG);
        chk("big_duty_r", duty2_r, BIG);
        chk("big_duty_g", duty2_g, BIG);
        chk("big_duty_b", duty2_b, BIG);
        chk("big_change_first", change2, 0);
        @(posedge clk); #1;
        k = 1;
        chk("big_valid_oneshot", valid2, 0);
        while (!valid2 && k < 4000) begin @(posedge clk); #1; k++; end
        chk("big_period", k, BIG);
        chk("big_duty_r_2", duty2_r, BIG);
        chk("big_change_2", change2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
